// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised input memory and its power FSM.
package mem_pkg;

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    SLEEP    = 2'd1,
    SHUTDOWN = 2'd2,
    WAKE     = 2'd3
  } pm_state_t;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 2;

  // Widest word the masked-write helper handles; callers zero-extend and truncate.
  localparam int unsigned MAX_DATA_W = 1024;

  // Active-low per-bit write: bits with bweb=1 keep their old value.
  function automatic logic [MAX_DATA_W-1:0] masked_write(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] wdata,
    input logic [MAX_DATA_W-1:0] bweb
  );
    return (old_word & bweb) | (wdata & ~bweb);
  endfunction

endpackage

// File: rtl/input_mem_pm_fsm.sv
// Power-state FSM: sleep/shutdown sequencing, wake-up counter, RDY and ERR_ACC.
module input_mem_pm_fsm
  import mem_pkg::*;
#(
  parameter int unsigned SLP_WAKE = 4,
  parameter int unsigned SD_WAKE  = 16
) (
  input  logic clk,
  input  logic rstb,
  input  logic i_slp,
  input  logic i_sd,
  input  logic i_ceb,
  output logic o_rdy,
  output logic o_err_acc
);

  localparam int unsigned MAX_WAKE = (SLP_WAKE > SD_WAKE) ? SLP_WAKE : SD_WAKE;
  localparam int unsigned CNT_W    = (MAX_WAKE > 1) ? $clog2(MAX_WAKE) : 1;

  pm_state_t          r_state;
  pm_state_t          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_rdy;
  logic               r_err_acc;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state   <= ACTIVE;
      r_cnt     <= '0;
      r_rdy     <= 1'b1;
      r_err_acc <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rdy     <= (w_state_nxt == ACTIVE);
      r_err_acc <= !i_ceb && !r_rdy;
    end
  end

  // Shutdown overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ACTIVE: begin
        if (i_slp) w_state_nxt = SLEEP;
      end
      SLEEP: begin
        if (!i_slp) begin
          w_state_nxt = WAKE;
          w_cnt_nxt   = CNT_W'(SLP_WAKE - 1);
        end
      end
      SHUTDOWN: begin
        if (i_slp) begin
          w_state_nxt = SLEEP;
        end else begin
          w_state_nxt = WAKE;
          w_cnt_nxt   = CNT_W'(SD_WAKE - 1);
        end
      end
      WAKE: begin
        if (i_slp) begin
          w_state_nxt = SLEEP;
        end else if (r_cnt == '0) begin
          w_state_nxt = ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ACTIVE;
    endcase
    if (i_sd) w_state_nxt = SHUTDOWN;
  end

  assign o_rdy     = r_rdy;
  assign o_err_acc = r_err_acc;

endmodule

// File: rtl/input_mem_pm.sv
// Behavioural single-port input memory with BIST mux, selectable read latency and power management.
module input_mem_pm
  import mem_pkg::*;
#(
  parameter int unsigned NUM_WORD = 32,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned ADDR_W   = $clog2(NUM_WORD),
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned SLP_WAKE = 4,
  parameter int unsigned SD_WAKE  = 16
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              BIST,
  input  logic              SLP,
  input  logic              SD,
  input  logic              CEB,
  input  logic              WEB,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] BWEB,
  input  logic              CEBM,
  input  logic              WEBM,
  input  logic [ADDR_W-1:0] AM,
  input  logic [DATA_W-1:0] DM,
  input  logic [DATA_W-1:0] BWEBM,
  input  logic [1:0]        RTSEL,
  input  logic [1:0]        WTSEL,
  output logic [DATA_W-1:0] Q,
  output logic              QVLD,
  output logic              RDY,
  output logic              ERR_ACC
);

  // Out-of-range latency settings fall back to the nearest legal value.
  localparam int unsigned RD_LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                                   (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

  logic              w_ce;
  logic              w_we;
  logic [ADDR_W-1:0] w_a;
  logic [DATA_W-1:0] w_d;
  logic [DATA_W-1:0] w_bweb;
  logic              w_rdy;
  logic              w_in_range;
  logic              w_acc;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_fin_vld;
  logic [DATA_W-1:0] w_fin_dat;

  logic [DATA_W-1:0] r_mem [NUM_WORD];
  logic [NUM_WORD-1:0] r_valid;
  logic [DATA_W-1:0] r_q;
  logic              r_qvld;
  logic [3:0]        r_tsel_unused;

  assign w_ce   = BIST ? CEBM  : CEB;
  assign w_we   = BIST ? WEBM  : WEB;
  assign w_a    = BIST ? AM    : A;
  assign w_d    = BIST ? DM    : D;
  assign w_bweb = BIST ? BWEBM : BWEB;

  assign w_in_range = (32'(w_a) < NUM_WORD);
  assign w_acc      = !w_ce && w_rdy && w_in_range;
  assign w_wr       = w_acc && !w_we;
  assign w_rd       = w_acc && w_we;
  assign w_rd_data  = r_valid[w_a] ? r_mem[w_a] : '0;

  input_mem_pm_fsm #(
    .SLP_WAKE (SLP_WAKE),
    .SD_WAKE  (SD_WAKE)
  ) u_fsm (
    .clk       (CLK),
    .rstb      (RSTB),
    .i_slp     (SLP),
    .i_sd      (SD),
    .i_ceb     (w_ce),
    .o_rdy     (w_rdy),
    .o_err_acc (ERR_ACC)
  );

  // Array contents survive reset and shutdown; only the valid bits are cleared.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[w_a] <= DATA_W'(masked_write(MAX_DATA_W'(r_mem[w_a]),
                                         MAX_DATA_W'(w_d),
                                         MAX_DATA_W'(w_bweb)));
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB || SD) begin
      r_valid <= '0;
    end else if (w_wr) begin
      r_valid[w_a] <= 1'b1;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign w_fin_vld = w_rd;
    assign w_fin_dat = w_rd_data;
  end else begin : g_lat2
    logic              r_s1_vld;
    logic [DATA_W-1:0] r_s1_dat;

    always_ff @(posedge CLK) begin
      if (!RSTB || SD) begin
        r_s1_vld <= 1'b0;
        r_s1_dat <= '0;
      end else begin
        r_s1_vld <= w_rd;
        if (w_rd) r_s1_dat <= w_rd_data;
      end
    end

    assign w_fin_vld = r_s1_vld;
    assign w_fin_dat = r_s1_dat;
  end

  // Q holds between reads; shutdown flushes it to zero.
  always_ff @(posedge CLK) begin
    if (!RSTB || SD) begin
      r_q    <= '0;
      r_qvld <= 1'b0;
    end else begin
      r_qvld <= w_fin_vld;
      if (w_fin_vld) r_q <= w_fin_dat;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) r_tsel_unused <= '0;
    else       r_tsel_unused <= {RTSEL, WTSEL};
  end

  assign Q    = r_q;
  assign QVLD = r_qvld;
  assign RDY  = w_rdy;

endmodule

// File: tb/tb_input_mem_pm.sv
// Bench for input_mem_pm: READ_LAT=1 and READ_LAT=2 instances share stimulus, reads are scoreboarded.
module tb_input_mem_pm;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 5;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  logic          clk;
  logic          rstb, bist, slp, sd;
  logic          ceb, web, cebm, webm;
  logic [AW-1:0] a, am;
  logic [DW-1:0] d, bweb, dm, bwebm;
  logic [1:0]    rtsel, wtsel;

  logic [DW-1:0] q1, q2;
  logic          qvld1, qvld2, rdy1, rdy2, err1, err2;
  logic [DW-1:0] q_o   [2];
  logic          qvld_o[2];
  logic          rdy_o [2];
  logic          err_o [2];

  int vectors;
  int miscompares;
  int cyc;

  // Index k of each scoreboard is the DUT whose read latency is k+1.
  exp_t sb[2][$];
  exp_t got;

  logic [DW-1:0] mdl [32];
  logic [31:0]   mdl_vld;

  input_mem_pm #(.READ_LAT(1)) u_dut_l1 (
    .CLK(clk), .RSTB(rstb), .BIST(bist), .SLP(slp), .SD(sd),
    .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
    .CEBM(cebm), .WEBM(webm), .AM(am), .DM(dm), .BWEBM(bwebm),
    .RTSEL(rtsel), .WTSEL(wtsel),
    .Q(q1), .QVLD(qvld1), .RDY(rdy1), .ERR_ACC(err1)
  );

  input_mem_pm #(.READ_LAT(2)) u_dut_l2 (
    .CLK(clk), .RSTB(rstb), .BIST(bist), .SLP(slp), .SD(sd),
    .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
    .CEBM(cebm), .WEBM(webm), .AM(am), .DM(dm), .BWEBM(bwebm),
    .RTSEL(rtsel), .WTSEL(wtsel),
    .Q(q2), .QVLD(qvld2), .RDY(rdy2), .ERR_ACC(err2)
  );

  assign q_o[0] = q1;     assign q_o[1] = q2;
  assign qvld_o[0] = qvld1; assign qvld_o[1] = qvld2;
  assign rdy_o[0] = rdy1; assign rdy_o[1] = rdy2;
  assign err_o[0] = err1; assign err_o[1] = err2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-data monitor: every QVLD must match the oldest expected read, on its due cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      while (sb[k].size() > 0 && sb[k][0].due < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL qvld_missing dut_l%0d cyc %0d: no QVLD, expected data %h due %0d",
                 k + 1, cyc, sb[k][0].d, sb[k][0].due);
        void'(sb[k].pop_front());
      end
      if (qvld_o[k] === 1'b1) begin
        vectors++;
        if (sb[k].size() == 0) begin
          miscompares++;
          $display("FAIL qvld_unexpected dut_l%0d cyc %0d: QVLD=1 Q=%h, no read pending",
                   k + 1, cyc, q_o[k]);
        end else begin
          got = sb[k].pop_front();
          if (q_o[k] !== got.d || got.due != cyc) begin
            miscompares++;
            $display("FAIL read_data dut_l%0d cyc %0d: Q=%h exp %h (due cyc %0d)",
                     k + 1, cyc, q_o[k], got.d, got.due);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Discard expected reads that a reset or shutdown at edge e will flush.
  task automatic drop_from(input int e);
    for (int k = 0; k < 2; k++)
      while (sb[k].size() > 0 && sb[k][$].due >= e) void'(sb[k].pop_back());
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW-1:0] mask);
    ceb = 1'b0; web = 1'b0; a = addr; d = data; bweb = mask;
    mdl[addr] = (mdl[addr] & mask) | (data & ~mask);
    mdl_vld[addr] = 1'b1;
    step();
    ceb = 1'b1; web = 1'b1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr);
    exp_t e;
    ceb = 1'b0; web = 1'b1; a = addr;
    e.d = mdl_vld[addr] ? mdl[addr] : '0;
    for (int k = 0; k < 2; k++) begin
      e.due = cyc + k + 1;
      sb[k].push_back(e);
    end
    step();
    ceb = 1'b1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (3) step();
    rstb = 1'b1;
    mdl_vld = '0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (rdy_o[k] !== 1'b1 || qvld_o[k] !== 1'b0 || err_o[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl dut_l%0d: RDY=%b QVLD=%b ERR=%b exp 1/0/0",
                 k + 1, rdy_o[k], qvld_o[k], err_o[k]);
      end
      vectors++;
      if (q_o[k] !== '0) begin
        miscompares++;
        $display("FAIL reset_q dut_l%0d: Q=%h exp 0", k + 1, q_o[k]);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(5'd3, {16{8'hA5}}, '0);
    do_read(5'd3);
    do_read(5'd9);
    repeat (3) step();
  endtask

  task automatic test_bweb();
    do_write(5'd5, '1, '0);
    do_write(5'd5, '0, {{64{1'b1}}, {64{1'b0}}});
    do_read(5'd5);
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ad;
    logic [DW-1:0] dv, mk;
    for (int i = 16; i < 24; i++) do_write(AW'(i), {$urandom, $urandom, $urandom, $urandom}, '0);
    for (int i = 0; i < 20; i++) begin
      ad = AW'(16 + $urandom_range(0, 7));
      dv = {$urandom, $urandom, $urandom, $urandom};
      mk = {$urandom, $urandom, $urandom, $urandom};
      do_write(ad, dv, mk);
      do_read(ad);
      do_read(AW'(16 + $urandom_range(0, 7)));
    end
    repeat (3) step();
  endtask

  task automatic test_sleep();
    int cnt[2];
    slp = 1'b1;
    do_read(5'd3);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (rdy_o[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL sleep_rdy dut_l%0d: RDY=%b exp 0", k + 1, rdy_o[k]);
      end
    end
    repeat (9) step();
    slp = 1'b0;
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rdy_o[0] === 1'b1 && rdy_o[1] === 1'b1) break;
      for (int k = 0; k < 2; k++) if (rdy_o[k] !== 1'b1) cnt[k]++;
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cnt[k] != 4) begin
        miscompares++;
        $display("FAIL slp_wake_len dut_l%0d: RDY low %0d cycles exp 4", k + 1, cnt[k]);
      end
      vectors++;
      if (q_o[k] !== {16{8'hA5}}) begin
        miscompares++;
        $display("FAIL q_hold dut_l%0d: Q=%h exp %h", k + 1, q_o[k], {16{8'hA5}});
      end
    end
    do_read(5'd3);
    repeat (3) step();
  endtask

  task automatic test_shutdown();
    int cnt[2];
    sd = 1'b1;
    drop_from(cyc + 1);
    mdl_vld = '0;
    step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (q_o[k] !== '0 || rdy_o[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL sd_entry dut_l%0d: Q=%h RDY=%b exp 0/0", k + 1, q_o[k], rdy_o[k]);
      end
    end
    repeat (2) step();
    sd = 1'b0;
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 2) begin ceb = 1'b0; web = 1'b1; a = 5'd3; end
      step();
      if (i == 2) begin
        ceb = 1'b1;
        for (int k = 0; k < 2; k++) begin
          vectors++;
          if (err_o[k] !== 1'b1 || q_o[k] !== '0) begin
            miscompares++;
            $display("FAIL err_acc dut_l%0d: ERR=%b Q=%h exp 1/0", k + 1, err_o[k], q_o[k]);
          end
        end
      end
      if (i == 3) begin
        for (int k = 0; k < 2; k++) begin
          vectors++;
          if (err_o[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse dut_l%0d: ERR=%b exp 0", k + 1, err_o[k]);
          end
        end
      end
      if (rdy_o[0] === 1'b1 && rdy_o[1] === 1'b1) break;
      for (int k = 0; k < 2; k++) if (rdy_o[k] !== 1'b1) cnt[k]++;
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cnt[k] != 16) begin
        miscompares++;
        $display("FAIL sd_wake_len dut_l%0d: RDY low %0d cycles exp 16", k + 1, cnt[k]);
      end
    end
    do_read(5'd3);
    repeat (3) step();
  endtask

  task automatic test_bist();
    exp_t e;
    bist = 1'b1;
    cebm = 1'b0; webm = 1'b0; am = 5'd7; dm = 128'h1234; bwebm = '0;
    ceb = 1'b0; web = 1'b0; a = 5'd7; d = 128'hFFFF; bweb = '0;
    mdl[7] = 128'h1234;
    mdl_vld[7] = 1'b1;
    step();
    ceb = 1'b1; web = 1'b1;
    webm = 1'b1;
    e.d = mdl[7];
    for (int k = 0; k < 2; k++) begin
      e.due = cyc + k + 1;
      sb[k].push_back(e);
    end
    step();
    cebm = 1'b1;
    bist = 1'b0;
    do_read(5'd7);
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    do_write(5'd5, 128'hDEAD_BEEF, '0);
    do_read(5'd5);
    rstb = 1'b0;
    drop_from(cyc + 1);
    mdl_vld = '0;
    step();
    rstb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (rdy_o[k] !== 1'b1 || qvld_o[k] !== 1'b0 || q_o[k] !== '0) begin
        miscompares++;
        $display("FAIL rst_mid_read dut_l%0d: RDY=%b QVLD=%b Q=%h exp 1/0/0",
                 k + 1, rdy_o[k], qvld_o[k], q_o[k]);
      end
    end
    slp = 1'b1;
    step();
    slp = 1'b0;
    repeat (2) step();
    rstb = 1'b0;
    step();
    rstb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (rdy_o[k] !== 1'b1 || qvld_o[k] !== 1'b0 || q_o[k] !== '0) begin
        miscompares++;
        $display("FAIL rst_mid_wake dut_l%0d: RDY=%b QVLD=%b Q=%h exp 1/0/0",
                 k + 1, rdy_o[k], qvld_o[k], q_o[k]);
      end
    end
    do_read(5'd5);
    do_write(5'd6, 128'h0BAD_F00D, '0);
    do_read(5'd6);
    repeat (3) step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rstb = 1'b0; bist = 1'b0; slp = 1'b0; sd = 1'b0;
    ceb = 1'b1; web = 1'b1; a = '0; d = '0; bweb = '1;
    cebm = 1'b1; webm = 1'b1; am = '0; dm = '0; bwebm = '1;
    rtsel = 2'b01; wtsel = 2'b10;
    mdl_vld = '0;

    test_reset();
    test_write_read();
    test_bweb();
    test_back_to_back();
    test_sleep();
    test_shutdown();
    test_bist();
    test_reset_mid();

    repeat (4) step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (sb[k].size() != 0) begin
        miscompares++;
        $display("FAIL sb_drain dut_l%0d: %0d reads outstanding exp 0", k + 1, sb[k].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
